// File: rtl/serial_divide_pkg.sv
// Shared types and defaults for the serial signed divide-by-power-of-2 stage.
package serial_divide_pkg;

  localparam int unsigned DEFAULT_N = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/serial_signed_divide_by_power_of_2.sv
// Multi-cycle signed divide by 2**s: one arithmetic shift per clock, with an
// optional round-toward-zero correction selected per transaction.
module serial_signed_divide_by_power_of_2
  import serial_divide_pkg::*;
#(
  parameter int unsigned N  = DEFAULT_N,
  parameter int unsigned SW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          up_valid,
  output logic          up_ready,
  input  logic [N-1:0]  up_data,
  input  logic [SW-1:0] up_shift,
  input  logic          up_trunc,
  output logic          down_valid,
  input  logic          down_ready,
  output logic [N-1:0]  down_data
);

  state_t        state_q, state_d;
  logic [N-1:0]  data_q, data_d;
  logic [SW-1:0] cnt_q, cnt_d;
  logic          mode_q, mode_d;
  logic          sticky_q, sticky_d;
  logic [N-1:0]  result_q, result_d;
  logic          up_ready_q, up_ready_d;
  logic          down_valid_q, down_valid_d;
  logic          inc;

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      data_q       <= '0;
      cnt_q        <= '0;
      mode_q       <= 1'b0;
      sticky_q     <= 1'b0;
      result_q     <= '0;
      up_ready_q   <= 1'b1;
      down_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      data_q       <= data_d;
      cnt_q        <= cnt_d;
      mode_q       <= mode_d;
      sticky_q     <= sticky_d;
      result_q     <= result_d;
      up_ready_q   <= up_ready_d;
      down_valid_q <= down_valid_d;
    end
  end

  // Next-state, shift datapath and registered handshake outputs
  always_comb begin
    state_d  = state_q;
    data_d   = data_q;
    cnt_d    = cnt_q;
    mode_d   = mode_q;
    sticky_d = sticky_q;
    result_d = result_q;
    // Truncation differs from floor only for negative values that lost a 1 bit
    inc      = mode_q & data_q[N-1] & sticky_q;

    case (state_q)
      IDLE: begin
        if (up_valid) begin
          data_d   = up_data;
          cnt_d    = up_shift;
          mode_d   = up_trunc;
          sticky_d = 1'b0;
          state_d  = SHIFT;
        end
      end
      SHIFT: begin
        if (cnt_q != '0) begin
          sticky_d = sticky_q | data_q[0];
          data_d   = {data_q[N-1], data_q[N-1:1]};
          cnt_d    = cnt_q - SW'(1);
        end else begin
          // Negative result plus one is at most zero, so this cannot overflow
          result_d = data_q + N'(inc);
          state_d  = DONE;
        end
      end
      DONE: begin
        if (down_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    up_ready_d   = (state_d == IDLE);
    down_valid_d = (state_d == DONE);
  end

  assign up_ready   = up_ready_q;
  assign down_valid = down_valid_q;
  assign down_data  = result_q;

endmodule

// File: tb/tb_serial_signed_divide_by_power_of_2.sv
// Scoreboard bench for the serial signed divide-by-power-of-2 stage.
module tb_serial_signed_divide_by_power_of_2;

  localparam int unsigned N  = 8;
  localparam int unsigned SW = 3;

  logic          clk;
  logic          rst_n;
  logic          up_valid;
  logic          up_ready;
  logic [N-1:0]  up_data;
  logic [SW-1:0] up_shift;
  logic          up_trunc;
  logic          down_valid;
  logic          down_ready;
  logic [N-1:0]  down_data;

  logic signed [N-1:0] exp_q[$];
  int n_checks = 0;
  int n_fails  = 0;
  int n_acc    = 0;
  int n_del    = 0;
  bit rnd_stall = 1'b0;

  serial_signed_divide_by_power_of_2 #(.N(N)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .up_valid   (up_valid),
    .up_ready   (up_ready),
    .up_data    (up_data),
    .up_shift   (up_shift),
    .up_trunc   (up_trunc),
    .down_valid (down_valid),
    .down_ready (down_ready),
    .down_data  (down_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Advance one cycle; inputs change 1 time unit after the rising edge
  task automatic step();
    @(posedge clk);
    #1;
    if (rnd_stall) down_ready = ($urandom_range(0, 2) != 0);
  endtask

  task automatic wait_idle();
    int b = 0;
    while (!up_ready && b < 300) begin
      step();
      b++;
    end
    check("idle_wait", int'(up_ready), 1);
  endtask

  task automatic send(input int a, input int s, input bit tr, input int e, input bit lat);
    int b = 0;
    exp_q.push_back(N'(e));
    up_data  = N'(a);
    up_shift = SW'(s);
    up_trunc = tr;
    up_valid = 1'b1;
    while (!up_ready && b < 300) begin
      step();
      b++;
    end
    check("accept_wait", int'(up_ready), 1);
    step();
    up_valid = 1'b0;
    up_data  = N'($urandom);
    up_shift = SW'($urandom);
    up_trunc = 1'($urandom);
    n_acc++;
    if (lat) begin
      for (int i = 0; i <= s; i++) begin
        check("latency_early", int'(down_valid), 0);
        step();
      end
      check("latency_valid", int'(down_valid), 1);
    end
  endtask

  // Monitor: a result transfers on the edge following a negedge with valid && ready
  always @(negedge clk) begin
    if (rst_n && down_valid && down_ready) begin
      n_del++;
      if (exp_q.size() == 0) begin
        check("unexpected_result", int'($signed(down_data)), 9999);
      end else begin
        check("result", int'($signed(down_data)), int'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic signed [N-1:0] ab;
    int ai, s, e;
    bit tr;

    rst_n      = 1'b0;
    up_valid   = 1'b0;
    up_data    = '0;
    up_shift   = '0;
    up_trunc   = 1'b0;
    down_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check("reset_up_ready", int'(up_ready), 1);
    check("reset_down_valid", int'(down_valid), 0);
    check("reset_down_data", int'(down_data), 0);

    // Directed vectors, latency checked on each
    send(-100, 3, 1'b0, -13, 1'b1); wait_idle();
    send(-100, 3, 1'b1, -12, 1'b1); wait_idle();
    send( 100, 3, 1'b0,  12, 1'b1); wait_idle();
    send( 100, 3, 1'b1,  12, 1'b1); wait_idle();
    send(  -1, 3, 1'b1,   0, 1'b1); wait_idle();
    send(  -1, 3, 1'b0,  -1, 1'b1); wait_idle();
    send(-128, 7, 1'b0,  -1, 1'b1); wait_idle();
    send(-128, 7, 1'b1,  -1, 1'b1); wait_idle();
    send(  -5, 0, 1'b0,  -5, 1'b1); wait_idle();
    send(  -5, 0, 1'b1,  -5, 1'b1); wait_idle();
    send( 127, 7, 1'b0,   0, 1'b1); wait_idle();
    send( 127, 7, 1'b1,   0, 1'b1); wait_idle();

    // Backpressure with an intruding offer during DONE
    down_ready = 1'b0;
    send(-100, 2, 1'b1, -25, 1'b0);
    for (int b = 0; b < 50 && !down_valid; b++) step();
    up_data  = N'(5);
    up_shift = SW'(0);
    up_trunc = 1'b0;
    up_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("bp_down_valid", int'(down_valid), 1);
      check("bp_down_data", int'($signed(down_data)), -25);
      check("bp_up_ready", int'(up_ready), 0);
      step();
    end
    down_ready = 1'b1;
    step();
    check("bp_release_up_ready", int'(up_ready), 1);
    check("bp_release_down_valid", int'(down_valid), 0);
    up_valid = 1'b0;
    repeat (3) step();
    check("bp_no_intruder", int'(down_valid), 0);

    // Asynchronous reset in the middle of a shift drops the transaction
    send(-64, 6, 1'b1, -1, 1'b0);
    repeat (2) step();
    #2;
    rst_n = 1'b0;
    #1;
    check("midreset_down_valid", int'(down_valid), 0);
    check("midreset_down_data", int'(down_data), 0);
    check("midreset_up_ready", int'(up_ready), 1);
    exp_q.delete();
    n_acc--;
    @(negedge clk);
    rst_n = 1'b1;
    step();
    send(64, 6, 1'b0, 1, 1'b1); wait_idle();

    // Random operands against a floor / truncating-divide model, random stalls
    rnd_stall = 1'b1;
    for (int t = 0; t < 1000; t++) begin
      ab = N'($urandom);
      ai = ab;
      s  = $urandom_range(0, N - 1);
      tr = 1'($urandom);
      e  = tr ? (ai / (1 << s)) : (ai >>> s);
      send(ai, s, tr, e, 1'b0);
    end
    rnd_stall  = 1'b0;
    down_ready = 1'b1;
    wait_idle();
    repeat (2) step();
    check("accepted_vs_delivered", n_del, n_acc);
    check("scoreboard_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
